// File: rtl/btb_fetch.sv
// btb_fetch: front-end fetch stage. Owns the fetch PC, drives the
// instruction-memory word address and predicts the next PC with a
// direct-mapped BTB holding 2-bit saturating counters.
//
// state   | meaning
// --------+-----------------------------------------------------------
// ST_INIT | sweeping BTB valid bits clear, one entry per cycle; no fetch
// ST_RUN  | fetching, predicting, accepting redirects and training
module btb_fetch #(
  parameter int          IDX_BITS = 10,
  parameter logic [15:0] RESET_PC = 16'h0000
) (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic        i_stall,
  input  logic        i_redirect_valid,
  input  logic [15:0] i_redirect_pc,
  input  logic        i_update_valid,
  input  logic [15:0] i_update_pc,
  input  logic        i_update_taken,
  input  logic [15:0] i_update_target,
  output logic [14:0] o_mem_raddr,
  output logic [15:0] o_fetch_pc,
  output logic        o_fetch_valid,
  output logic [15:0] o_fetch_pred_pc
);

  localparam int ENTRIES  = 1 << IDX_BITS;
  localparam int TAG_BITS = 15 - IDX_BITS;

  typedef enum logic {
    ST_INIT,
    ST_RUN
  } state_t;

  state_t r_state;
  state_t w_state_nxt;

  logic [IDX_BITS-1:0] r_init_idx;
  logic [15:0]         r_pc;
  logic [15:0]         r_fetch_pc;
  logic                r_fetch_valid;
  logic [15:0]         r_fetch_pred_pc;

  logic                r_valid  [ENTRIES];
  logic [TAG_BITS-1:0] r_tag    [ENTRIES];
  logic [15:0]         r_target [ENTRIES];
  logic [1:0]          r_ctr    [ENTRIES];

  logic [IDX_BITS-1:0] w_idx;
  logic [TAG_BITS-1:0] w_tag;
  logic                w_hit;
  logic                w_taken;
  logic [15:0]         w_pc_plus2;
  logic [15:0]         w_pred;

  logic [IDX_BITS-1:0] w_uidx;
  logic [TAG_BITS-1:0] w_utag;
  logic                w_uhit;
  logic                w_unused_pc_lsb;

  // Lookup on the current PC; the read sees pre-update contents.
  assign w_idx      = r_pc[IDX_BITS:1];
  assign w_tag      = r_pc[15:IDX_BITS+1];
  assign w_hit      = r_valid[w_idx] && (r_tag[w_idx] == w_tag);
  assign w_taken    = w_hit && r_ctr[w_idx][1];
  assign w_pc_plus2 = r_pc + 16'd2;
  assign w_pred     = (w_taken ? r_target[w_idx] : w_pc_plus2) & 16'hFFFE;

  assign w_uidx          = i_update_pc[IDX_BITS:1];
  assign w_utag          = i_update_pc[15:IDX_BITS+1];
  assign w_uhit          = r_valid[w_uidx] && (r_tag[w_uidx] == w_utag);
  assign w_unused_pc_lsb = i_update_pc[0];

  assign o_mem_raddr     = r_pc[15:1];
  assign o_fetch_pc      = r_fetch_pc;
  assign o_fetch_valid   = r_fetch_valid;
  assign o_fetch_pred_pc = r_fetch_pred_pc;

  // State register.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state <= ST_INIT;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next state: leave INIT after the last entry has been cleared.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_INIT: if (r_init_idx == {IDX_BITS{1'b1}}) w_state_nxt = ST_RUN;
      ST_RUN:  w_state_nxt = ST_RUN;
      default: w_state_nxt = ST_INIT;
    endcase
  end

  // INIT sweep pointer.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_init_idx <= '0;
    end else if (r_state == ST_INIT) begin
      r_init_idx <= r_init_idx + 1'b1;
    end
  end

  // PC and fetch outputs: redirect beats stall beats prediction.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_pc            <= RESET_PC;
      r_fetch_pc      <= 16'h0000;
      r_fetch_valid   <= 1'b0;
      r_fetch_pred_pc <= 16'h0000;
    end else if (r_state == ST_RUN) begin
      if (i_redirect_valid) begin
        r_pc          <= i_redirect_pc & 16'hFFFE;
        r_fetch_valid <= 1'b0;
      end else if (!i_stall) begin
        r_pc            <= w_pred;
        r_fetch_pc      <= r_pc;
        r_fetch_pred_pc <= w_pred;
        r_fetch_valid   <= 1'b1;
      end
    end
  end

  // BTB writes: INIT clears valid bits, RUN trains from resolved branches.
  always_ff @(posedge i_clk) begin
    if (!i_reset) begin
      if (r_state == ST_INIT) begin
        r_valid[r_init_idx] <= 1'b0;
      end else if (i_update_valid) begin
        if (w_uhit) begin
          if (i_update_taken) begin
            if (r_ctr[w_uidx] != 2'd3) r_ctr[w_uidx] <= r_ctr[w_uidx] + 2'd1;
            r_target[w_uidx] <= i_update_target;
          end else if (r_ctr[w_uidx] != 2'd0) begin
            r_ctr[w_uidx] <= r_ctr[w_uidx] - 2'd1;
          end
        end else if (i_update_taken) begin
          r_valid[w_uidx]  <= 1'b1;
          r_tag[w_uidx]    <= w_utag;
          r_target[w_uidx] <= i_update_target;
          r_ctr[w_uidx]    <= 2'd2;
        end
      end
    end
  end

endmodule

// File: tb/tb_btb_fetch.sv
// Bench for btb_fetch: directed scenarios plus random traffic, all checked
// against a behavioural model of the fetch PC and BTB.
module tb_btb_fetch;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        stall = 1'b0;
  logic        redirect_valid = 1'b0;
  logic [15:0] redirect_pc = 16'h0;
  logic        update_valid = 1'b0;
  logic [15:0] update_pc = 16'h0;
  logic        update_taken = 1'b0;
  logic [15:0] update_target = 16'h0;
  logic [14:0] mem_raddr;
  logic [15:0] fetch_pc;
  logic        fetch_valid;
  logic [15:0] fetch_pred_pc;

  int n_cmp = 0;
  int n_err = 0;

  btb_fetch dut (
    .i_clk           (clk),
    .i_reset         (reset),
    .i_stall         (stall),
    .i_redirect_valid(redirect_valid),
    .i_redirect_pc   (redirect_pc),
    .i_update_valid  (update_valid),
    .i_update_pc     (update_pc),
    .i_update_taken  (update_taken),
    .i_update_target (update_target),
    .o_mem_raddr     (mem_raddr),
    .o_fetch_pc      (fetch_pc),
    .o_fetch_valid   (fetch_valid),
    .o_fetch_pred_pc (fetch_pred_pc)
  );

  always #5 clk = ~clk;

  // Reference model: each entry remembers the full branch PC it was trained on.
  typedef struct {
    bit          v;
    logic [15:0] bpc;
    logic [15:0] tgt;
    int          ctr;
  } ent_t;

  ent_t        mbtb [1024];
  bit          m_run;
  int          m_init_left;
  logic [15:0] m_pc, m_fpc, m_fpred;
  logic        m_fv;

  function automatic int bidx(logic [15:0] pc);
    return (int'(pc) / 2) % 1024;
  endfunction

  function automatic bit same_branch(logic [15:0] a, logic [15:0] b);
    return (int'(a) / 2) == (int'(b) / 2);
  endfunction

  function automatic logic [15:0] mpredict(logic [15:0] pc);
    int i;
    i = bidx(pc);
    if (mbtb[i].v && same_branch(mbtb[i].bpc, pc) && mbtb[i].ctr >= 2)
      return mbtb[i].tgt & 16'hFFFE;
    return 16'((int'(pc) + 2) % 65536);
  endfunction

  task automatic model_edge();
    logic [15:0] pred;
    int i;
    if (reset) begin
      m_run = 0; m_init_left = 1024;
      m_pc = 16'h0; m_fpc = 16'h0; m_fpred = 16'h0; m_fv = 1'b0;
      for (int k = 0; k < 1024; k++) mbtb[k].v = 1'b0;
      return;
    end
    if (!m_run) begin
      m_init_left--;
      if (m_init_left == 0) m_run = 1;
      return;
    end
    pred = mpredict(m_pc);
    if (redirect_valid) begin
      m_pc = redirect_pc & 16'hFFFE;
      m_fv = 1'b0;
    end else if (!stall) begin
      m_fpc = m_pc; m_fpred = pred; m_fv = 1'b1; m_pc = pred;
    end
    if (update_valid) begin
      i = bidx(update_pc);
      if (mbtb[i].v && same_branch(mbtb[i].bpc, update_pc)) begin
        if (update_taken) begin
          mbtb[i].ctr = (mbtb[i].ctr < 3) ? mbtb[i].ctr + 1 : 3;
          mbtb[i].tgt = update_target;
        end else begin
          mbtb[i].ctr = (mbtb[i].ctr > 0) ? mbtb[i].ctr - 1 : 0;
        end
      end else if (update_taken) begin
        mbtb[i].v = 1'b1; mbtb[i].bpc = update_pc;
        mbtb[i].tgt = update_target; mbtb[i].ctr = 2;
      end
    end
  endtask

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Drive one cycle of inputs, clock it, update the model and compare.
  task automatic step(input bit rst, input bit st, input bit rv, input logic [15:0] rpc,
                      input bit uv, input logic [15:0] upc, input bit ut,
                      input logic [15:0] utgt);
    reset = rst; stall = st;
    redirect_valid = rv; redirect_pc = rpc;
    update_valid = uv; update_pc = upc; update_taken = ut; update_target = utgt;
    @(posedge clk);
    #1;
    model_edge();
    chk("fetch_valid", {15'h0, fetch_valid}, {15'h0, m_fv});
    chk("fetch_pc", fetch_pc, m_fpc);
    chk("fetch_pred_pc", fetch_pred_pc, m_fpred);
    chk("mem_raddr", {1'b0, mem_raddr}, {1'b0, m_pc[15:1]});
  endtask

  task automatic idle();
    step(0, 0, 0, 16'h0, 0, 16'h0, 0, 16'h0);
  endtask

  task automatic redir(input logic [15:0] pc);
    step(0, 0, 1, pc, 0, 16'h0, 0, 16'h0);
  endtask

  task automatic upd(input logic [15:0] pc, input bit t, input logic [15:0] tgt);
    step(0, 0, 0, 16'h0, 1, pc, t, tgt);
  endtask

  function automatic logic [15:0] rnd_pc();
    return 16'(($urandom_range(0, 3) << 11) | ($urandom_range(0, 7) << 1));
  endfunction

  // Random stimulus; INIT-time redirects/updates/stalls must be ignored.
  task automatic noise(input int n);
    for (int k = 0; k < n; k++)
      step(0, ($urandom_range(0, 4) == 0), ($urandom_range(0, 7) == 0),
           rnd_pc() | 16'($urandom_range(0, 1)),
           ($urandom_range(0, 1) == 1), rnd_pc(), ($urandom_range(0, 9) < 6),
           rnd_pc() | 16'($urandom_range(0, 1)));
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  initial begin
    // Reset and INIT
    step(1, 0, 0, 16'h0, 0, 16'h0, 0, 16'h0);
    step(1, 0, 0, 16'h0, 0, 16'h0, 0, 16'h0);
    chk("reset_valid", {15'h0, fetch_valid}, 16'h0);
    chk("reset_raddr", {1'b0, mem_raddr}, 16'h0);
    noise(1024);
    chk("init_raddr", {1'b0, mem_raddr}, 16'h0);
    chk("init_valid", {15'h0, fetch_valid}, 16'h0);

    // First fetches
    idle(); chk("first_pc0", fetch_pc, 16'h0000); chk("first_v", {15'h0, fetch_valid}, 16'h1);
    idle(); chk("first_pc1", fetch_pc, 16'h0002);
    idle(); chk("first_pc2", fetch_pc, 16'h0004);

    // Redirect with odd PC
    redir(16'h0041);
    chk("redir_raddr", {1'b0, mem_raddr}, 16'h0020);
    chk("redir_kill", {15'h0, fetch_valid}, 16'h0);
    idle(); chk("redir_fpc", fetch_pc, 16'h0040);

    // Allocation and prediction
    upd(16'h0010, 1, 16'h0100);
    redir(16'h0010);
    idle(); chk("alloc_fpc", fetch_pc, 16'h0010); chk("alloc_pred", fetch_pred_pc, 16'h0100);
    chk("alloc_raddr", {1'b0, mem_raddr}, 16'h0080);

    // Saturation
    upd(16'h0010, 1, 16'h0100); upd(16'h0010, 1, 16'h0100); upd(16'h0010, 1, 16'h0100);
    upd(16'h0010, 0, 16'h0000);
    redir(16'h0010);
    idle(); chk("sat_pred_t", fetch_pred_pc, 16'h0100);
    upd(16'h0010, 0, 16'h0000);
    redir(16'h0010);
    idle(); chk("sat_pred_nt", fetch_pred_pc, 16'h0012);

    // Alias / tag check, with simultaneous redirect and update
    upd(16'h0010, 1, 16'h0100);
    redir(16'h0810);
    idle(); chk("alias_pred", fetch_pred_pc, 16'h0812);
    step(0, 0, 1, 16'h0010, 1, 16'h0810, 1, 16'h0200);
    idle(); chk("alias_evict", fetch_pred_pc, 16'h0012);
    redir(16'h0810);
    idle(); chk("alias_new", fetch_pred_pc, 16'h0200);

    // Read-before-write on the same index
    redir(16'h0030);
    upd(16'h0030, 1, 16'h0300);
    chk("rbw_old", fetch_pred_pc, 16'h0032);
    redir(16'h0030);
    idle(); chk("rbw_new", fetch_pred_pc, 16'h0300);

    // Stall hold
    idle();
    for (int k = 0; k < 3; k++) step(0, 1, 0, 16'h0, 0, 16'h0, 0, 16'h0);
    chk("stall_v", {15'h0, fetch_valid}, 16'h1);

    // Wrap
    redir(16'hFFFE);
    idle(); chk("wrap_fpc", fetch_pc, 16'hFFFE); chk("wrap_pred", fetch_pred_pc, 16'h0000);
    chk("wrap_raddr", {1'b0, mem_raddr}, 16'h0000);

    // Random traffic in RUN
    noise(2000);

    // Reset during stall restarts INIT
    step(0, 1, 0, 16'h0, 0, 16'h0, 0, 16'h0);
    step(1, 1, 0, 16'h0, 0, 16'h0, 0, 16'h0);
    chk("rst_stall_v", {15'h0, fetch_valid}, 16'h0);
    noise(1024);
    chk("reinit_v", {15'h0, fetch_valid}, 16'h0);
    idle(); chk("reinit_fpc", fetch_pc, 16'h0000);
    noise(300);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
